// File: rtl/lcd_pkg.sv
// Shared constants, opcodes and state encoding for the LCD text controller.
// Cell addresses are 0-15 for line 1 and 16-31 for line 2.
package lcd_pkg;

    localparam int LCD_CELLS    = 32;
    localparam int LCD_LINE_LEN = 16;

    localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

    localparam logic [1:0] OP_PUTC    = 2'd0;
    localparam logic [1:0] OP_SETCUR  = 2'd1;
    localparam logic [1:0] OP_CLEAR   = 2'd2;
    localparam logic [1:0] OP_NEWLINE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    // Last cell of the line that holds addr.
    function automatic logic [4:0] line_end(input logic [4:0] addr);
        return addr | 5'(LCD_LINE_LEN - 1);
    endfunction

endpackage

// File: rtl/lcd_text_ctrl.sv
// Text controller for a 2x16 LCD character buffer: accepts PUTC/SETCUR/CLEAR/NEWLINE
// commands and turns them into one-per-cycle writes on the buffer's write port.
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] FILL_CHAR      = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        lcd_write,
    output logic [15:0] lcd_bus,
    output logic [4:0]  cursor,
    output logic        busy
);

    state_t      r_state, w_state_nx;
    logic        r_pending_clear;
    logic [4:0]  r_cursor, w_cursor_nx;
    logic [4:0]  r_fill_addr, w_fill_addr_nx;
    logic [4:0]  r_fill_end, w_fill_end_nx;
    logic [4:0]  r_fill_dest, w_fill_dest_nx;
    logic        r_lcd_write, w_lcd_write_nx;
    logic [15:0] r_lcd_bus, w_lcd_bus_nx;

    logic        w_accept;
    logic        w_is_newline;
    logic        w_start_fill;
    logic [4:0]  w_fill_start, w_fill_stop, w_fill_to;

    // The post-reset clear is pending for one cycle before FILL starts; keep the port closed then too.
    assign cmd_ready    = (r_state == ST_IDLE) && !rst && !r_pending_clear;
    assign busy         = !rst && ((r_state != ST_IDLE) || r_pending_clear);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_is_newline = (cmd_op == OP_NEWLINE) ||
                          ((cmd_op == OP_PUTC) && (cmd_data == NEWLINE_CHAR));

    assign lcd_write = r_lcd_write;
    assign lcd_bus   = r_lcd_bus;
    assign cursor    = r_cursor;

    // Fill range selection: CLEAR covers the whole buffer, NEWLINE the rest of the current line.
    always_comb begin
        w_start_fill = 1'b0;
        w_fill_start = r_cursor;
        w_fill_stop  = line_end(r_cursor);
        w_fill_to    = (r_cursor < 5'(LCD_LINE_LEN)) ? 5'(LCD_LINE_LEN) : 5'd0;
        if (r_pending_clear || (w_accept && (cmd_op == OP_CLEAR))) begin
            w_start_fill = 1'b1;
            w_fill_start = 5'd0;
            w_fill_stop  = 5'(LCD_CELLS - 1);
            w_fill_to    = 5'd0;
        end else if (w_accept && w_is_newline) begin
            w_start_fill = 1'b1;
        end else begin
            w_start_fill = 1'b0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx     = r_state;
        w_cursor_nx    = r_cursor;
        w_fill_addr_nx = r_fill_addr;
        w_fill_end_nx  = r_fill_end;
        w_fill_dest_nx = r_fill_dest;
        w_lcd_write_nx = 1'b0;
        w_lcd_bus_nx   = r_lcd_bus;
        case (r_state)
            ST_IDLE: begin
                if (w_start_fill) begin
                    w_state_nx     = ST_FILL;
                    w_lcd_write_nx = 1'b1;
                    w_lcd_bus_nx   = {3'b000, w_fill_start, FILL_CHAR};
                    w_fill_addr_nx = w_fill_start;
                    w_fill_end_nx  = w_fill_stop;
                    w_fill_dest_nx = w_fill_to;
                end else if (w_accept && (cmd_op == OP_PUTC)) begin
                    w_state_nx     = ST_WRITE;
                    w_lcd_write_nx = 1'b1;
                    w_lcd_bus_nx   = {3'b000, r_cursor, cmd_data};
                    w_cursor_nx    = r_cursor + 5'd1;
                end else if (w_accept && (cmd_op == OP_SETCUR)) begin
                    w_cursor_nx = cmd_data[4:0];
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_state_nx = ST_IDLE;
            end
            ST_FILL: begin
                if (r_fill_addr == r_fill_end) begin
                    w_state_nx  = ST_IDLE;
                    w_cursor_nx = r_fill_dest;
                end else begin
                    w_lcd_write_nx = 1'b1;
                    w_fill_addr_nx = r_fill_addr + 5'd1;
                    w_lcd_bus_nx   = {3'b000, r_fill_addr + 5'd1, FILL_CHAR};
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pending_clear <= CLEAR_ON_RESET;
            r_cursor        <= 5'd0;
            r_fill_addr     <= 5'd0;
            r_fill_end      <= 5'd0;
            r_fill_dest     <= 5'd0;
            r_lcd_write     <= 1'b0;
            r_lcd_bus       <= 16'h0000;
        end else begin
            r_state         <= w_state_nx;
            r_pending_clear <= 1'b0;
            r_cursor        <= w_cursor_nx;
            r_fill_addr     <= w_fill_addr_nx;
            r_fill_end      <= w_fill_end_nx;
            r_fill_dest     <= w_fill_dest_nx;
            r_lcd_write     <= w_lcd_write_nx;
            r_lcd_bus       <= w_lcd_bus_nx;
        end
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Self-checking bench for lcd_text_ctrl: directed vector table, multi-cycle corner
// sequences, and a buffer scoreboard over a random command stream.
module tb_lcd_text_ctrl;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;

    logic        ready_a, write_a, busy_a, ready_b, write_b, busy_b;
    logic [15:0] bus_a, bus_b;
    logic [4:0]  cursor_a, cursor_b;

    logic        sel;
    logic        w_ready, w_write, w_busy;
    logic [15:0] w_bus;
    logic [4:0]  w_cursor;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] wq[$];
    logic [7:0]  shadow[32];
    logic [7:0]  mdl[32];

    always #5 clk = ~clk;

    lcd_text_ctrl u_dut_a (
        .clk(clk), .rst(rst_a), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .lcd_write(write_a), .lcd_bus(bus_a),
        .cursor(cursor_a), .busy(busy_a)
    );

    lcd_text_ctrl #(.CLEAR_ON_RESET(1'b0), .FILL_CHAR(8'h20)) u_dut_b (
        .clk(clk), .rst(rst_b), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .lcd_write(write_b), .lcd_bus(bus_b),
        .cursor(cursor_b), .busy(busy_b)
    );

    assign w_ready  = sel ? ready_b  : ready_a;
    assign w_write  = sel ? write_b  : write_a;
    assign w_busy   = sel ? busy_b   : busy_a;
    assign w_bus    = sel ? bus_b    : bus_a;
    assign w_cursor = sel ? cursor_b : cursor_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: records every write and updates the observed buffer image.
    always @(negedge clk) begin
        if (w_write === 1'b1) begin
            wq.push_back(w_bus);
            if (!sel) shadow[w_bus[12:8]] = w_bus[7:0];
            chk("reserved_bits_zero", 32'(w_bus[15:13]), 32'd0);
            chk("write_only_when_busy", 32'(w_busy), 32'd1);
        end
    end

    task automatic wait_ready(input string name);
        int t = 0;
        while (w_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (w_ready !== 1'b1) chk(name, 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data,
                         output int nw, output logic [15:0] first, output logic [15:0] last,
                         output bit seq_ok);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        wait_ready("accept_timeout");
        wq.delete();
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_ready("complete_timeout");
        nw     = wq.size();
        first  = (nw > 0) ? wq[0] : 16'h0000;
        last   = (nw > 0) ? wq[nw-1] : 16'h0000;
        seq_ok = 1'b1;
        for (int i = 1; i < nw; i++)
            if (wq[i][12:8] != wq[i-1][12:8] + 5'd1) seq_ok = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        int          nw;
        logic [15:0] first;
        logic [15:0] last;
        logic [4:0]  cur;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int          nw, cyc;
        logic [15:0] first, last;
        bit          seq_ok;
        logic [1:0]  op;
        logic [7:0]  data;
        int          mcur;

        vecs[0]  = '{OP_SETCUR,  8'h1F, 0,  16'h0000, 16'h0000, 5'd31};
        vecs[1]  = '{OP_PUTC,    8'h41, 1,  16'h1F41, 16'h1F41, 5'd0};
        vecs[2]  = '{OP_PUTC,    8'h42, 1,  16'h0042, 16'h0042, 5'd1};
        vecs[3]  = '{OP_SETCUR,  8'h05, 0,  16'h0000, 16'h0000, 5'd5};
        vecs[4]  = '{OP_NEWLINE, 8'h00, 11, 16'h0520, 16'h0F20, 5'd16};
        vecs[5]  = '{OP_SETCUR,  8'h1F, 0,  16'h0000, 16'h0000, 5'd31};
        vecs[6]  = '{OP_PUTC,    8'h0A, 1,  16'h1F20, 16'h1F20, 5'd0};
        vecs[7]  = '{OP_SETCUR,  8'h0F, 0,  16'h0000, 16'h0000, 5'd15};
        vecs[8]  = '{OP_NEWLINE, 8'h00, 1,  16'h0F20, 16'h0F20, 5'd16};
        vecs[9]  = '{OP_NEWLINE, 8'h55, 16, 16'h1020, 16'h1F20, 5'd0};
        vecs[10] = '{OP_PUTC,    8'h0A, 16, 16'h0020, 16'h0F20, 5'd16};
        vecs[11] = '{OP_SETCUR,  8'hE7, 0,  16'h0000, 16'h0000, 5'd7};
        vecs[12] = '{OP_PUTC,    8'h7E, 1,  16'h077E, 16'h077E, 5'd8};
        vecs[13] = '{OP_SETCUR,  8'h10, 0,  16'h0000, 16'h0000, 5'd16};
        vecs[14] = '{OP_PUTC,    8'h51, 1,  16'h1051, 16'h1051, 5'd17};

        sel       = 1'b0;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_PUTC;
        cmd_data  = 8'h00;

        #12;
        chk("rst_write",  32'(write_a),  32'd0);
        chk("rst_bus",    32'(bus_a),    32'd0);
        chk("rst_cursor", 32'(cursor_a), 32'd0);
        chk("rst_busy",   32'(busy_a),   32'd0);
        chk("rst_ready",  32'(ready_a),  32'd0);

        // Reset release with auto-clear.
        @(negedge clk);
        wq.delete();
        rst_a = 1'b0;
        #1;
        chk("autoclr_ready_low", 32'(ready_a), 32'd0);
        chk("autoclr_busy_high", 32'(busy_a),  32'd1);
        wait_ready("autoclr_timeout");
        seq_ok = 1'b1;
        for (int i = 1; i < wq.size(); i++)
            if (wq[i][12:8] != wq[i-1][12:8] + 5'd1) seq_ok = 1'b0;
        chk("autoclr_count", 32'(wq.size()), 32'd32);
        if (wq.size() > 0) begin
            chk("autoclr_first", 32'(wq[0]), 32'h0020);
            chk("autoclr_last",  32'(wq[wq.size()-1]), 32'h1F20);
        end
        chk("autoclr_seq",    32'(seq_ok),   32'd1);
        chk("autoclr_cursor", 32'(cursor_a), 32'd0);

        // Directed command table.
        for (int v = 0; v < 15; v++) begin
            issue(vecs[v].op, vecs[v].data, nw, first, last, seq_ok);
            chk($sformatf("vec%0d_nwrites", v), 32'(nw), 32'(vecs[v].nw));
            if (vecs[v].nw > 0) begin
                chk($sformatf("vec%0d_first", v), 32'(first), 32'(vecs[v].first));
                chk($sformatf("vec%0d_last", v),  32'(last),  32'(vecs[v].last));
                chk($sformatf("vec%0d_seq", v),   32'(seq_ok), 32'd1);
            end
            chk($sformatf("vec%0d_cursor", v), 32'(cursor_a), 32'(vecs[v].cur));
        end

        // PUTC held valid during a CLEAR is accepted only once the clear is done.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        wait_ready("hold_accept_timeout");
        wq.delete();
        @(posedge clk);
        @(negedge clk);
        cmd_op   = OP_PUTC;
        cmd_data = 8'h78;
        cyc      = 0;
        while (ready_a !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_wait_cycles", 32'(cyc), 32'd32);
        chk("hold_fill_count",  32'(wq.size()), 32'd32);
        if (wq.size() > 0) chk("hold_fill_last", 32'(wq[wq.size()-1]), 32'h1F20);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold_putc_write", 32'(write_a), 32'd1);
        chk("hold_putc_bus",   32'(bus_a),   32'h0078);
        wait_ready("hold_done_timeout");
        chk("hold_putc_total", 32'(wq.size()), 32'd33);
        chk("hold_cursor",     32'(cursor_a),  32'd1);

        // Scoreboard over a random command stream.
        issue(OP_CLEAR, 8'h00, nw, first, last, seq_ok);
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        mcur = 0;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    op   = OP_PUTC;
                    data = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
                end
                6, 7:    begin op = OP_SETCUR;  data = 8'($urandom_range(0, 255)); end
                8:       begin op = OP_NEWLINE; data = 8'($urandom_range(0, 255)); end
                default: begin op = OP_CLEAR;   data = 8'($urandom_range(0, 255)); end
            endcase
            issue(op, data, nw, first, last, seq_ok);
            if (op == OP_SETCUR) begin
                mcur = int'(data[4:0]);
            end else if (op == OP_CLEAR) begin
                for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
                mcur = 0;
            end else if (op == OP_NEWLINE || data == 8'h0A) begin
                for (int a = mcur; a <= ((mcur < 16) ? 15 : 31); a++) mdl[a] = 8'h20;
                mcur = (mcur < 16) ? 16 : 0;
            end else begin
                mdl[mcur] = data;
                mcur = (mcur + 1) % 32;
            end
            chk($sformatf("sb_cursor_%0d", n), 32'(cursor_a), 32'(mcur));
        end
        for (int i = 0; i < 32; i++)
            chk($sformatf("sb_cell_%0d", i), 32'(shadow[i]), 32'(mdl[i]));

        // Second instance without auto-clear: reset aborts a CLEAR mid-way.
        @(negedge clk);
        rst_a = 1'b1;
        sel   = 1'b1;
        #1;
        chk("b_rst_write", 32'(write_b), 32'd0);
        chk("b_rst_ready", 32'(ready_b), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("b_ready_no_autoclr", 32'(ready_b), 32'd1);
        chk("b_busy_no_autoclr",  32'(busy_b),  32'd0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        wait_ready("b_accept_timeout");
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        chk("b_10th_write", 32'(write_b), 32'd1);
        chk("b_10th_bus",   32'(bus_b),   32'h0920);
        rst_b = 1'b1;
        #1;
        chk("b_abort_write",  32'(write_b),  32'd0);
        chk("b_abort_bus",    32'(bus_b),    32'd0);
        chk("b_abort_cursor", 32'(cursor_b), 32'd0);
        chk("b_abort_busy",   32'(busy_b),   32'd0);
        chk("b_abort_ready",  32'(ready_b),  32'd0);
        wq.delete();
        @(negedge clk);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("b_no_writes_after_abort", 32'(wq.size()), 32'd0);
        issue(OP_PUTC, 8'h5A, nw, first, last, seq_ok);
        chk("b_putc_nwrites", 32'(nw),       32'd1);
        chk("b_putc_bus",     32'(first),    32'h005A);
        chk("b_putc_cursor",  32'(cursor_b), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
